mini68k_bus_unit: RTL and testbench

//  Parametrised 68000-style bus interface unit between the mini68k core and external memory.

---
 rtl/mini68k_pkg.sv | 27 ++
 rtl/mini68k_sync.sv | 20 ++
 rtl/mini68k_bus_unit.sv | 207 ++++++++++++++++++++
 tb/tb_mini68k_bus_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mini68k_pkg.sv
// Shared encodings for the mini68k bus interface unit: transfer sizes, FSM states
// and 68000 function codes.
package mini68k_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_WORD = 2'b01,
        SZ_LONG = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ASSERT,
        ST_WAIT,
        ST_TERM,
        ST_GRANT,
        ST_EXT
    } state_e;

    localparam logic [2:0] FC_USER_DATA = 3'd1;
    localparam logic [2:0] FC_USER_PROG = 3'd2;
    localparam logic [2:0] FC_SUPV_DATA = 3'd5;
    localparam logic [2:0] FC_SUPV_PROG = 3'd6;
    localparam logic [2:0] FC_INT_ACK   = 3'd7;

endpackage

// File: rtl/mini68k_sync.sv
// Reset-to-1 flop chain for the asynchronous, active-low bus handshake inputs.
module mini68k_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] ff_q;

    always_ff @(posedge clk) begin
        if (!rst_n) ff_q <= '1;
        else        ff_q <= STAGES'({ff_q, d_i});
    end

    assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/mini68k_bus_unit.sv
// 68000-style bus interface unit: core request -> AS/DS/DTACK bus cycles, long splitting
// on a 16-bit bus, bus-error/timeout termination and BR/BG/BGACK arbitration.
module mini68k_bus_unit
    import mini68k_pkg::*;
#(
    parameter int ADDR_W      = 24,
    parameter int DATA_W      = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic                req_we,
    input  logic [1:0]          req_size,
    input  logic [2:0]          req_fc,
    input  logic [31:0]         req_wdata,
    output logic                rsp_valid,
    output logic [31:0]         rsp_rdata,
    output logic                rsp_berr,
    output logic                rsp_aerr,
    output logic [ADDR_W-1:0]   addr,
    output logic [2:0]          fc,
    output logic                rw,
    output logic                as_n,
    output logic [DATA_W/8-1:0] ds_n,
    output logic [DATA_W-1:0]   data_out,
    input  logic [DATA_W-1:0]   data_in,
    output logic                bus_oe,
    output logic                data_oe,
    input  logic                dtack_n,
    input  logic                berr_n,
    input  logic                br_n,
    output logic                bg_n,
    input  logic                bgack_n
);

    localparam int NL    = DATA_W / 8;
    localparam int OW    = $clog2(NL);
    localparam int CW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam bit SPLIT = (DATA_W == 16);

    logic dtack_s, berr_s, br_s, bgack_s;

    mini68k_sync #(.STAGES(SYNC_STAGES)) u_sync_dtack (.clk(clk), .rst_n(rst_n), .d_i(dtack_n), .q_o(dtack_s));
    mini68k_sync #(.STAGES(SYNC_STAGES)) u_sync_berr  (.clk(clk), .rst_n(rst_n), .d_i(berr_n),  .q_o(berr_s));
    mini68k_sync #(.STAGES(SYNC_STAGES)) u_sync_br    (.clk(clk), .rst_n(rst_n), .d_i(br_n),    .q_o(br_s));
    mini68k_sync #(.STAGES(SYNC_STAGES)) u_sync_bgack (.clk(clk), .rst_n(rst_n), .d_i(bgack_n), .q_o(bgack_s));

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        fc_q, fc_d;
    logic              rw_q, rw_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
    logic              beat_q, beat_d, last_q, last_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d, rsp_berr_q, rsp_berr_d, rsp_aerr_q, rsp_aerr_d;

    // Lane geometry of the current beat: nb bytes, placed sh lanes up from lane 0.
    int                nb, sh;
    logic [63:0]       bmask;
    logic [NL-1:0]     lanes;
    logic [31:0]       chunk, rd_piece;
    logic [DATA_W-1:0] wr_lanes;
    logic              long2, misalign, timeout, strobe;

    assign long2 = SPLIT && (size_q == SZ_LONG);

    always_comb begin
        nb = 1;
        if (size_q == SZ_WORD || long2) nb = 2;
        else if (size_q == SZ_LONG)     nb = 4;
        sh       = NL - nb - int'(addr_q[OW-1:0]);
        bmask    = (64'd1 << (8 * nb)) - 64'd1;
        lanes    = NL'((32'd1 << nb) - 32'd1) << sh;
        chunk    = (long2 && !beat_q) ? {16'h0, wdata_q[31:16]} : wdata_q;
        wr_lanes = DATA_W'((64'(chunk) & bmask) << (8 * sh));
        rd_piece = 32'((64'(data_in) >> (8 * sh)) & bmask);
    end

    assign misalign = (req_size == 2'b11)
                   || (req_size == SZ_WORD && req_addr[0])
                   || (req_size == SZ_LONG && (req_addr[0] || (!SPLIT && req_addr[1])));
    assign timeout  = (TIMEOUT_CYC != 0) && (cnt_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        fc_d        = fc_q;
        rw_d        = rw_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        beat_d      = beat_q;
        last_d      = last_q;
        cnt_d       = '0;
        rsp_valid_d = 1'b0;
        rsp_berr_d  = 1'b0;
        rsp_aerr_d  = 1'b0;
        req_ready   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                req_ready = br_s;
                rw_d      = 1'b1;
                if (!br_s) begin
                    state_d = ST_GRANT;
                end else if (req_valid) begin
                    if (misalign) begin
                        rsp_valid_d = 1'b1;
                        rsp_aerr_d  = 1'b1;
                    end else begin
                        state_d = ST_ADDR;
                        addr_d  = req_addr;
                        fc_d    = req_fc;
                        rw_d    = ~req_we;
                        size_d  = req_size;
                        wdata_d = req_wdata;
                        beat_d  = 1'b0;
                    end
                end
            end
            // Hold the address phase until the previous slave has released DTACK.
            ST_ADDR:   if (dtack_s) state_d = ST_ASSERT;
            ST_ASSERT: state_d = ST_WAIT;
            ST_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (!berr_s || timeout) begin
                    state_d     = ST_TERM;
                    last_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_berr_d  = 1'b1;
                end else if (!dtack_s) begin
                    state_d     = ST_TERM;
                    last_d      = !(long2 && !beat_q);
                    rsp_valid_d = last_d;
                    rdata_d     = (long2 && beat_q) ? {rdata_q[15:0], rd_piece[15:0]} : rd_piece;
                end
            end
            ST_TERM: begin
                if (last_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_ADDR;
                    beat_d  = 1'b1;
                    addr_d  = addr_q + ADDR_W'(2);
                end
            end
            ST_GRANT: begin
                if (!bgack_s)  state_d = ST_EXT;
                else if (br_s) state_d = ST_IDLE;
            end
            ST_EXT:  if (bgack_s && br_s) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            fc_q        <= '0;
            rw_q        <= 1'b1;
            size_q      <= SZ_BYTE;
            wdata_q     <= '0;
            rdata_q     <= '0;
            beat_q      <= 1'b0;
            last_q      <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_berr_q  <= 1'b0;
            rsp_aerr_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            fc_q        <= fc_d;
            rw_q        <= rw_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            beat_q      <= beat_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_berr_q  <= rsp_berr_d;
            rsp_aerr_q  <= rsp_aerr_d;
        end
    end

    assign strobe    = (state_q == ST_ASSERT) || (state_q == ST_WAIT);
    assign as_n      = ~strobe;
    assign ds_n      = strobe ? ~lanes : '1;
    assign addr      = addr_q;
    assign fc        = fc_q;
    assign rw        = rw_q;
    assign data_out  = wr_lanes;
    assign data_oe   = ~rw_q && (state_q inside {ST_ADDR, ST_ASSERT, ST_WAIT});
    assign bus_oe    = !(state_q inside {ST_GRANT, ST_EXT});
    assign bg_n      = (state_q != ST_GRANT);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_berr  = rsp_berr_q;
    assign rsp_aerr  = rsp_aerr_q;

endmodule

// File: tb/tb_mini68k_bus_unit.sv
// Randomised bench: a byte-addressed memory model predicts bus beats, lanes, read data
// and latency for a 16-bit unit; a 32-bit instance covers the wide-bus lane mapping.
module tb_mini68k_bus_unit;
    import mini68k_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_we, req_ready;
    logic [23:0] req_addr;
    logic [1:0]  req_size;
    logic [2:0]  req_fc;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_berr, rsp_aerr;
    logic [31:0] rsp_rdata;
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        rw, as_n, bus_oe, data_oe, dtack_n, berr_n, br_n, bg_n, bgack_n;
    logic [1:0]  ds_n;
    logic [15:0] data_out, data_in;

    logic        r32_valid, r32_ready, r32_rsp, r32_berr, r32_aerr;
    logic [31:0] r32_rdata, data_out32;
    logic [23:0] addr32;
    logic [2:0]  fc32;
    logic        rw32, as32_n, bus_oe32, data_oe32, bg32_n;
    logic [3:0]  ds32_n;

    logic        slave_en, berr_en;
    int          n_chk = 0, n_fail = 0, n_rsp = 0, n_beat32 = 0;
    logic [3:0]  ds32_seen;
    logic        as_prev = 1'b1, as32_prev = 1'b1;

    typedef struct {
        logic [23:0] a;
        logic [1:0]  ds;
        logic        rw;
        logic [2:0]  fc;
        logic        oe;
        logic [15:0] d;
    } beat_t;
    beat_t beats[$];

    logic [7:0] smem [int];
    logic [7:0] rmem [int];

    always #5 clk = ~clk;

    mini68k_bus_unit #(.ADDR_W(24), .DATA_W(16), .SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_fc(req_fc), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_berr(rsp_berr), .rsp_aerr(rsp_aerr),
        .addr(addr), .fc(fc), .rw(rw), .as_n(as_n), .ds_n(ds_n), .data_out(data_out),
        .data_in(data_in), .bus_oe(bus_oe), .data_oe(data_oe), .dtack_n(dtack_n),
        .berr_n(berr_n), .br_n(br_n), .bg_n(bg_n), .bgack_n(bgack_n));

    mini68k_bus_unit #(.ADDR_W(24), .DATA_W(32), .SYNC_STAGES(2), .TIMEOUT_CYC(255)) dut32 (
        .clk(clk), .rst_n(rst_n), .req_valid(r32_valid), .req_ready(r32_ready), .req_addr(req_addr),
        .req_we(req_we), .req_size(req_size), .req_fc(req_fc), .req_wdata(req_wdata),
        .rsp_valid(r32_rsp), .rsp_rdata(r32_rdata), .rsp_berr(r32_berr), .rsp_aerr(r32_aerr),
        .addr(addr32), .fc(fc32), .rw(rw32), .as_n(as32_n), .ds_n(ds32_n), .data_out(data_out32),
        .data_in(32'hCAFEF00D), .bus_oe(bus_oe32), .data_oe(data_oe32), .dtack_n(as32_n),
        .berr_n(1'b1), .br_n(br_n), .bg_n(bg32_n), .bgack_n(bgack_n));

    // Slaves acknowledge combinationally as soon as AS falls.
    assign dtack_n = ~(slave_en & ~as_n);
    assign berr_n  = ~(berr_en & ~as_n);

    function automatic logic [7:0] srd(int a);
        return smem.exists(a) ? smem[a] : (8'(a) ^ 8'h5A);
    endfunction

    function automatic logic [7:0] rrd(int a);
        return rmem.exists(a) ? rmem[a] : (8'(a) ^ 8'h5A);
    endfunction

    function automatic logic [31:0] rexp(int a, int n);
        logic [31:0] r = '0;
        for (int k = 0; k < n; k++) r = (r << 8) | 32'(rrd(a + k));
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus-side slave memory and beat log, sampled mid-cycle.
    always @(negedge clk) begin
        if (as_prev && !as_n) begin
            beats.push_back('{a: addr, ds: ds_n, rw: rw, fc: fc, oe: data_oe, d: data_out});
            if (!rw) begin
                if (!ds_n[1]) smem[int'({addr[23:1], 1'b0})] = data_out[15:8];
                if (!ds_n[0]) smem[int'({addr[23:1], 1'b1})] = data_out[7:0];
            end
        end
        as_prev = as_n;
        data_in = {srd(int'({addr[23:1], 1'b0})), srd(int'({addr[23:1], 1'b1}))};
        if (rsp_valid) n_rsp++;
        if (as32_prev && !as32_n) begin
            n_beat32++;
            ds32_seen = ds32_n;
        end
        as32_prev = as32_n;
    end

    // Issue one request; returns with lat = edges after the accept edge until rsp_valid is seen.
    task automatic run16(input logic [23:0] a, input logic [1:0] sz, input logic we,
                         input logic [31:0] wd, input logic [2:0] f, output int lat, output bit ok);
        beats.delete();
        @(negedge clk);
        req_addr = a; req_size = sz; req_we = we; req_wdata = wd; req_fc = f; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            req_valid = 1'b0;
            lat = -1;
            return;
        end
        @(posedge clk); #1 req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic txn16(input logic [23:0] a, input logic [1:0] sz, input logic we,
                         input logic [31:0] wd, input logic [2:0] f);
        int lat, n, nbeat;
        bit ok, bad;
        logic [31:0] rd;
        logic [23:0] ba;
        logic [7:0] gotb;
        n   = (sz == SZ_BYTE) ? 1 : (sz == SZ_WORD) ? 2 : 4;
        bad = (sz != SZ_BYTE) && a[0];
        rd  = rexp(int'(a), n);
        run16(a, sz, we, wd, f, lat, ok);
        if (!ok) return;
        if (bad) begin
            check("aerr_lat", lat, 0);
            check("aerr_flag", rsp_aerr, 1);
        end else begin
            // 2+SYNC per beat; the second long beat also waits SYNC cycles for DTACK release.
            check("latency", lat, (sz == SZ_LONG) ? 10 : 4);
            check("aerr_clear", rsp_aerr, 0);
            check("berr_clear", rsp_berr, 0);
            if (!we) check("rdata", rsp_rdata, rd);
            check("term_data_oe", data_oe, 0);
            check("term_as_n", as_n, 1);
            check("term_ds_n", ds_n, 2'b11);
        end
        @(posedge clk); #1 check("rsp_pulse", rsp_valid, 0);
        repeat (3) @(posedge clk);
        nbeat = bad ? 0 : (sz == SZ_LONG) ? 2 : 1;
        check("n_beats", beats.size(), nbeat);
        for (int i = 0; i < nbeat && i < beats.size(); i++) begin
            check("beat_addr", beats[i].a, (sz == SZ_LONG) ? a + 24'(2 * i) : a);
            check("beat_ds_n", beats[i].ds, (sz == SZ_BYTE) ? (a[0] ? 2'b10 : 2'b01) : 2'b00);
            check("beat_rw", beats[i].rw, !we);
            check("beat_fc", beats[i].fc, f);
            check("beat_data_oe", beats[i].oe, we);
            if (we) begin
                for (int k = 0; k < n; k++) begin
                    if (((sz == SZ_LONG) ? k / 2 : 0) == i) begin
                        ba   = a + 24'(k);
                        gotb = ba[0] ? beats[i].d[7:0] : beats[i].d[15:8];
                        check("beat_wdata", gotb, 8'(wd >> (8 * (n - 1 - k))));
                    end
                end
            end
        end
        if (we && !bad)
            for (int k = 0; k < n; k++) rmem[int'(a) + k] = 8'(wd >> (8 * (n - 1 - k)));
    endtask

    task automatic txn32(input logic [23:0] a, input logic [1:0] sz, input logic exp_aerr,
                         input logic [3:0] exp_ds, input logic [31:0] exp_rd);
        int lat;
        bit ok = 1'b0;
        n_beat32 = 0;
        @(negedge clk);
        req_addr = a; req_size = sz; req_we = 1'b0; req_fc = FC_SUPV_DATA; r32_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (r32_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) begin
            check("w32_accept_timeout", 0, 1);
            r32_valid = 1'b0;
            return;
        end
        @(posedge clk); #1 r32_valid = 1'b0;
        lat = 0;
        while (!r32_rsp && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("w32_aerr", r32_aerr, exp_aerr);
        if (!exp_aerr) begin
            check("w32_latency", lat, 4);
            check("w32_rdata", r32_rdata, exp_rd);
        end
        repeat (4) @(posedge clk);
        check("w32_beats", n_beat32, exp_aerr ? 0 : 1);
        if (!exp_aerr) check("w32_ds_n", ds32_seen, exp_ds);
    endtask

    initial begin
        int lat, n0;
        bit ok;
        rst_n = 1'b0; req_valid = 1'b0; r32_valid = 1'b0; req_we = 1'b0; req_addr = '0;
        req_size = SZ_BYTE; req_fc = '0; req_wdata = '0; br_n = 1'b1; bgack_n = 1'b1;
        slave_en = 1'b1; berr_en = 1'b0;
        smem[32'h100] = 8'hBE; smem[32'h101] = 8'hEF;
        rmem[32'h100] = 8'hBE; rmem[32'h101] = 8'hEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_as_n", as_n, 1);
        check("rst_ds_n", ds_n, 2'b11);
        check("rst_rw", rw, 1);
        check("rst_bg_n", bg_n, 1);
        check("rst_bus_oe", bus_oe, 1);
        check("rst_data_oe", data_oe, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_addr", addr, 0);
        check("rst_fc", fc, 0);
        check("rst_ds32_n", ds32_n, 4'hF);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);

        txn16(24'h000100, SZ_WORD, 1'b0, 32'h0, FC_USER_DATA);
        txn16(24'h000200, SZ_LONG, 1'b1, 32'h12345678, FC_SUPV_DATA);
        txn16(24'h000200, SZ_LONG, 1'b0, 32'h0, FC_SUPV_DATA);
        txn16(24'h000301, SZ_BYTE, 1'b1, 32'h000000AA, FC_USER_DATA);
        txn16(24'h000301, SZ_WORD, 1'b0, 32'h0, FC_USER_DATA);
        txn16(24'h000301, SZ_LONG, 1'b1, 32'hDEADBEEF, FC_USER_DATA);

        for (int i = 0; i < 40; i++)
            txn16(24'($urandom_range(0, 255)), 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                  $urandom, 3'($urandom_range(1, 7)));

        // Silent slave: forced bus error after TIMEOUT_CYC wait cycles.
        slave_en = 1'b0;
        run16(24'h000010, SZ_WORD, 1'b0, 32'h0, FC_USER_DATA, lat, ok);
        check("tmo_latency", lat, 2 + 16);
        check("tmo_berr", rsp_berr, 1);
        slave_en = 1'b1;
        repeat (5) @(posedge clk);

        // BERR together with DTACK on the first beat of a long aborts the second beat.
        berr_en = 1'b1;
        run16(24'h000020, SZ_LONG, 1'b0, 32'h0, FC_USER_DATA, lat, ok);
        check("berr_latency", lat, 4);
        check("berr_flag", rsp_berr, 1);
        berr_en = 1'b0;
        repeat (15) @(posedge clk);
        check("berr_beats", beats.size(), 1);

        // Arbitration: external master takes the bus while a request is pending.
        @(negedge clk) br_n = 1'b0;
        repeat (3) @(negedge clk);
        check("grant_bg_n", bg_n, 0);
        check("grant_bus_oe", bus_oe, 0);
        req_addr = 24'h000100; req_size = SZ_WORD; req_we = 1'b0; req_fc = FC_USER_DATA;
        req_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("grant_ready", req_ready, 0);
        end
        bgack_n = 1'b0;
        repeat (4) @(negedge clk);
        check("ext_bg_n", bg_n, 1);
        check("ext_bus_oe", bus_oe, 0);
        check("ext_ready", req_ready, 0);
        check("ext_as_n", as_n, 1);
        br_n = 1'b1; bgack_n = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) begin ok = 1'b1; break; end
        end
        check("ext_release", ok, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        check("release_bus_oe", bus_oe, 1);
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check("after_grant_rdata", rsp_rdata, rexp(32'h100, 2));
        repeat (4) @(posedge clk);

        // Reset while waiting for DTACK: strobes drop on the next edge, no response ever.
        slave_en = 1'b0;
        @(negedge clk);
        req_addr = 24'h000040; req_size = SZ_WORD; req_we = 1'b1; req_wdata = 32'h1234;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("rstw_accept", ok, 1);
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("rstw_in_wait", as_n, 0);
        @(negedge clk) rst_n = 1'b0;
        n0 = n_rsp;
        @(posedge clk); #1;
        check("rstw_as_n", as_n, 1);
        check("rstw_ds_n", ds_n, 2'b11);
        check("rstw_data_oe", data_oe, 0);
        check("rstw_bus_oe", bus_oe, 1);
        @(negedge clk) rst_n = 1'b1;
        slave_en = 1'b1;
        repeat (25) @(posedge clk);
        check("rstw_no_rsp", n_rsp, n0);

        // 32-bit bus: lane 3 carries byte offset 0; a long is a single beat.
        txn32(24'h000400, SZ_LONG, 1'b0, 4'b0000, 32'hCAFEF00D);
        txn32(24'h000403, SZ_BYTE, 1'b0, 4'b1110, 32'h0000000D);
        txn32(24'h000400, SZ_BYTE, 1'b0, 4'b0111, 32'h000000CA);
        txn32(24'h000402, SZ_WORD, 1'b0, 4'b1100, 32'h0000F00D);
        txn32(24'h000402, SZ_LONG, 1'b1, 4'b1111, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "global timeout");
    end

endmodule
